// File: rtl/pc_sequencer_pkg.sv
// Shared PCControl encodings for the program-counter sequencer.
// Codes 5-7 are reserved and decode as SEQ.
package pc_seq_pkg;

  localparam int PCCTRL_W = 3;

  localparam logic [PCCTRL_W-1:0] SEQ    = 3'd0;
  localparam logic [PCCTRL_W-1:0] BRANCH = 3'd1;
  localparam logic [PCCTRL_W-1:0] JUMP   = 3'd2;
  localparam logic [PCCTRL_W-1:0] CALL   = 3'd3;
  localparam logic [PCCTRL_W-1:0] RET    = 3'd4;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular LIFO return stack; a push while full overwrites the oldest entry.
// Latency: push/pop commit on the rising edge, top is combinational.
// Backpressure: none; over/underflow are reported as single-cycle events.
module return_stack_p #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W:0]   count;

  // DEPTH is a power of two, so the pointer wraps naturally; a push while full
  // lands on the oldest slot, which is exactly the circular-overwrite rule.
  assign top_ptr = wptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign ovf_evt = push & full;
  assign unf_evt = pop & ~push & empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + PTR_W'(1);
      if (!full) count <= count + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      wptr  <= top_ptr;
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with sequential/branch/jump/call/return select; PC_TRAP_EN redirects stack faults to TRAP_VEC.
// Latency: new PC on PC_out one cycle after a PCWrite edge; SeqPC is combinational.
// Backpressure: none; PCWrite=0 freezes PC, stack and flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                RS_DEPTH  = 8,
  parameter int                INST_STEP = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(16'h0010)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                PCWrite,
  input  logic [PCCTRL_W-1:0] PCControl,
  input  logic [ADDR_W-1:0]   Target,
  input  logic [ADDR_W-1:0]   Offset,
  output logic [ADDR_W-1:0]   PC_out,
  output logic [ADDR_W-1:0]   SeqPC,
  output logic                RSFull,
  output logic                RSEmpty,
  output logic                RSOverflow,
  output logic                RSUnderflow,
  output logic                AddrWrap
);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W:0]   seq_sum;
  logic [ADDR_W:0]   br_sum;
  logic              br_wrap;
  logic [ADDR_W-1:0] next_pc;
  logic              next_wrap;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W-1:0] rs_top;
  logic              rs_full;
  logic              rs_empty;
  logic              ovf_evt;
  logic              unf_evt;

  assign seq_sum = {1'b0, PC_out} + (ADDR_W+1)'(INST_STEP);
  assign br_sum  = {1'b0, PC_out} + {1'b0, Offset};
  assign SeqPC   = seq_sum[ADDR_W-1:0];
  // Negative offsets stay in range only when the unsigned add carries out.
  assign br_wrap = br_sum[ADDR_W] ^ Offset[ADDR_W-1];

  always_comb begin
    next_pc   = SeqPC;
    next_wrap = seq_sum[ADDR_W];
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (PCControl)
      BRANCH: begin
        next_pc   = br_sum[ADDR_W-1:0];
        next_wrap = br_wrap;
      end
      JUMP: begin
        next_pc   = Target;
        next_wrap = 1'b0;
      end
      CALL: begin
        do_push   = PCWrite;
        next_pc   = (TRAP_EN && rs_full) ? TRAP_VEC : Target;
        next_wrap = 1'b0;
      end
      RET: begin
        do_pop    = PCWrite;
        next_pc   = rs_empty ? (TRAP_EN ? TRAP_VEC : SeqPC) : rs_top;
        next_wrap = 1'b0;
      end
      default: ;
    endcase
  end

  return_stack_p #(
    .WIDTH (ADDR_W),
    .DEPTH (RS_DEPTH)
  ) u_rs (
    .clk     (CLK),
    .reset   (Reset),
    .push    (do_push),
    .pop     (do_pop),
    .wdata   (SeqPC),
    .top     (rs_top),
    .full    (rs_full),
    .empty   (rs_empty),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  assign RSFull  = rs_full;
  assign RSEmpty = rs_empty;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      PC_out      <= RESET_PC;
      RSOverflow  <= 1'b0;
      RSUnderflow <= 1'b0;
      AddrWrap    <= 1'b0;
    end else begin
      AddrWrap <= PCWrite & next_wrap;
      if (PCWrite) begin
        PC_out      <= next_pc;
        RSOverflow  <= RSOverflow | ovf_evt;
        RSUnderflow <= RSUnderflow | unf_evt;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table plus hand sequences for nested calls, hold and reset; expectations via a scoreboard queue.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [15:0] TV = 16'h0010;

  logic        clk = 1'b0;
  logic        Reset, PCWrite;
  logic [2:0]  PCControl;
  logic [15:0] Target, Offset, PC_out, SeqPC;
  logic        RSFull, RSEmpty, RSOverflow, RSUnderflow, AddrWrap;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(16), .RS_DEPTH(8), .INST_STEP(2), .RESET_PC(16'h0000), .TRAP_VEC(TV)
  ) dut (
    .CLK(clk), .Reset(Reset), .PCWrite(PCWrite), .PCControl(PCControl),
    .Target(Target), .Offset(Offset), .PC_out(PC_out), .SeqPC(SeqPC),
    .RSFull(RSFull), .RSEmpty(RSEmpty), .RSOverflow(RSOverflow),
    .RSUnderflow(RSUnderflow), .AddrWrap(AddrWrap)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic e, f, o, u, w;
  } exp_t;

  typedef struct packed {
    logic        rst, pcw;
    logic [2:0]  ctrl;
    logic [15:0] tgt, off;
    exp_t        x;
  } vec_t;

  vec_t        tbl [21];
  exp_t        sb [$];
  logic [15:0] sm [$];
  int          n_run = 0;
  int          n_fail = 0;

  function automatic exp_t ex(logic [15:0] pc, logic e, logic f, logic o, logic u, logic w);
    return {pc, e, f, o, u, w};
  endfunction

  function automatic vec_t v(logic rst, logic pcw, logic [2:0] ctrl, logic [15:0] tgt,
                             logic [15:0] off, exp_t x);
    return {rst, pcw, ctrl, tgt, off, x};
  endfunction

  task automatic step(input string nm, input logic rst, input logic pcw, input logic [2:0] ctrl,
                      input logic [15:0] tgt, input logic [15:0] off, input exp_t x);
    exp_t        e;
    exp_t        got;
    logic [15:0] seq_exp;
    @(negedge clk);
    Reset = rst; PCWrite = pcw; PCControl = ctrl; Target = tgt; Offset = off;
    sb.push_back(x);
    @(posedge clk);
    #1;
    e       = sb.pop_front();
    seq_exp = 16'(e.pc + 16'd2);
    got     = {PC_out, RSEmpty, RSFull, RSOverflow, RSUnderflow, AddrWrap};
    n_run++;
    if (got !== e || SeqPC !== seq_exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%h seq=%h efouw=%b%b%b%b%b, want pc=%h seq=%h efouw=%b%b%b%b%b",
               nm, got.pc, SeqPC, got.e, got.f, got.o, got.u, got.w,
               e.pc, seq_exp, e.e, e.f, e.o, e.u, e.w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] mpc;
    logic        ovf;
    logic        was_full;

    Reset = 1'b1; PCWrite = 1'b0; PCControl = SEQ; Target = '0; Offset = '0;

    tbl[0]  = v(1, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0000, 1, 0, 0, 0, 0));
    tbl[1]  = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0002, 1, 0, 0, 0, 0));
    tbl[2]  = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0004, 1, 0, 0, 0, 0));
    tbl[3]  = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0006, 1, 0, 0, 0, 0));
    tbl[4]  = v(0, 1, JUMP,   16'h0010, 16'h0000, ex(16'h0010, 1, 0, 0, 0, 0));
    tbl[5]  = v(0, 1, CALL,   16'h0100, 16'h0000, ex(16'h0100, 0, 0, 0, 0, 0));
    tbl[6]  = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0102, 0, 0, 0, 0, 0));
    tbl[7]  = v(0, 1, RET,    16'h0000, 16'h0000, ex(16'h0012, 1, 0, 0, 0, 0));
    tbl[8]  = v(0, 1, JUMP,   16'hFFFE, 16'h0000, ex(16'hFFFE, 1, 0, 0, 0, 0));
    tbl[9]  = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0000, 1, 0, 0, 0, 1));
    tbl[10] = v(0, 1, SEQ,    16'h0000, 16'h0000, ex(16'h0002, 1, 0, 0, 0, 0));
    tbl[11] = v(0, 1, JUMP,   16'h0020, 16'h0000, ex(16'h0020, 1, 0, 0, 0, 0));
    tbl[12] = v(0, 1, BRANCH, 16'h0000, 16'hFFF0, ex(16'h0010, 1, 0, 0, 0, 0));
    tbl[13] = v(0, 1, BRANCH, 16'h0000, 16'h0008, ex(16'h0018, 1, 0, 0, 0, 0));
    tbl[14] = v(0, 1, JUMP,   16'hFFF0, 16'h0000, ex(16'hFFF0, 1, 0, 0, 0, 0));
    tbl[15] = v(0, 1, BRANCH, 16'h0000, 16'h0020, ex(16'h0010, 1, 0, 0, 0, 1));
    tbl[16] = v(0, 1, JUMP,   16'h0004, 16'h0000, ex(16'h0004, 1, 0, 0, 0, 0));
    tbl[17] = v(0, 1, BRANCH, 16'h0000, 16'hFFF0, ex(16'hFFF4, 1, 0, 0, 0, 1));
    tbl[18] = v(0, 1, 3'd5,   16'h1234, 16'h0040, ex(16'hFFF6, 1, 0, 0, 0, 0));
    tbl[19] = v(0, 1, 3'd7,   16'h1234, 16'h0040, ex(16'hFFF8, 1, 0, 0, 0, 0));
    tbl[20] = v(0, 0, CALL,   16'h1234, 16'h0000, ex(16'hFFF8, 1, 0, 0, 0, 0));

    for (int i = 0; i < 21; i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].pcw, tbl[i].ctrl,
           tbl[i].tgt, tbl[i].off, tbl[i].x);

    // Nested calls past the stack depth, then unwind, then one return too many.
    step("nest_rst", 1, 1, SEQ, 16'h0, 16'h0, ex(16'h0000, 1, 0, 0, 0, 0));
    step("nest_jmp", 0, 1, JUMP, 16'h1000, 16'h0, ex(16'h1000, 1, 0, 0, 0, 0));
    mpc = 16'h1000;
    ovf = 1'b0;
    sm.delete();
    for (int i = 1; i <= 9; i++) begin
      was_full = (sm.size() == 8);
      sm.push_back(16'(mpc + 16'd2));
      if (sm.size() > 8) void'(sm.pop_front());
      ovf = ovf | was_full;
      mpc = (TRAP && was_full) ? TV : 16'(16'h2000 + 16'(i * 16));
      step($sformatf("call%0d", i), 0, 1, CALL, 16'(16'h2000 + 16'(i * 16)), 16'h0,
           ex(mpc, 0, sm.size() == 8, ovf, 0, 0));
    end
    for (int j = 1; j <= 8; j++) begin
      mpc = sm.pop_back();
      step($sformatf("ret%0d", j), 0, 1, RET, 16'h0, 16'h0,
           ex(mpc, sm.size() == 0, 0, 1, 0, 0));
    end
    mpc = TRAP ? TV : 16'(mpc + 16'd2);
    step("ret_empty", 0, 1, RET, 16'h0, 16'h0, ex(mpc, 1, 0, 1, 1, 0));

    // Freeze with a pending CALL, then reset in the middle of the call sequence.
    step("hold_call", 0, 1, CALL, 16'h0400, 16'h0, ex(16'h0400, 0, 0, 1, 1, 0));
    for (int k = 0; k < 4; k++)
      step($sformatf("hold%0d", k), 0, 0, CALL, 16'h0500, 16'h0, ex(16'h0400, 0, 0, 1, 1, 0));
    step("mid_rst", 1, 1, CALL, 16'h0500, 16'h0, ex(16'h0000, 1, 0, 0, 0, 0));
    step("post_seq", 0, 1, SEQ, 16'h0, 16'h0, ex(16'h0002, 1, 0, 0, 0, 0));
    step("ret_unf", 0, 1, RET, 16'h0, 16'h0, ex(TRAP ? TV : 16'h0004, 1, 0, 0, 1, 0));
    step("unf_sticky", 0, 1, SEQ, 16'h0, 16'h0,
         ex(16'(TRAP ? TV + 16'd2 : 16'h0006), 1, 0, 0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the stack processor.
- Holds the PC and selects the next PC from sequential, relative-branch, absolute-jump, call and return sources.
- Owns a parametrised-depth return stack with full/empty status and sticky error flags.
- Sits between control unit (PCWrite/PCControl) and instruction memory (PC_out drives the fetch address).

Parameters:
- ADDR_W, 16, PC and address width in bits.
- RS_DEPTH, 8, return-stack entries; power of two, at least 2.
- INST_STEP, 2, byte increment per sequential instruction.
- RESET_PC, 0, PC value loaded on reset.
- TRAP_VEC, 16'h0010, trap target; used only with PC_TRAP_EN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  PC update enable; when 0, PC and stack hold.
- PCControl  in  3  next-PC select; encodings in package.
- Target  in  ADDR_W  absolute jump/call target.
- Offset  in  ADDR_W  signed two's-complement branch offset.
- PC_out  out  ADDR_W  current PC.
- SeqPC  out  ADDR_W  combinational PC_out+INST_STEP, modulo 2^ADDR_W.
- RSFull  out  1  return stack holds RS_DEPTH entries.
- RSEmpty  out  1  return stack holds 0 entries.
- RSOverflow  out  1  sticky: a call was made while full.
- RSUnderflow  out  1  sticky: a return was made while empty.
- AddrWrap  out  1  one-cycle pulse: the committed next-PC computation carried or overflowed.

Behaviour:
- Reset: PC_out=RESET_PC, stack count=0, RSEmpty=1, RSFull=0, RSOverflow=0, RSUnderflow=0, AddrWrap=0. Reset overrides PCWrite.
- PCControl encodings:
  - SEQ=0: PC<=SeqPC.
  - BRANCH=1: PC<=PC_out+Offset.
  - JUMP=2: PC<=Target.
  - CALL=3: push SeqPC; PC<=Target.
  - RET=4: PC<=top of stack; pop.
  - 5-7 reserved: behave as SEQ.
- All updates occur only when PCWrite=1. Latency: the new PC is visible on PC_out one cycle after the qualifying edge.
- Arithmetic: ADDR_W-bit modulo; the result wraps.
- AddrWrap=1 for the cycle after a committed SEQ or BRANCH whose true result falls outside 0..2^ADDR_W-1. For BRANCH, this uses an unsigned PC plus a sign-extended Offset.
- Return stack is LIFO with count 0..RS_DEPTH; the top entry is readable combinationally.
- CALL while full: the oldest entry is discarded (circular overwrite), count stays RS_DEPTH, RSOverflow set; the PC still jumps.
- RET while empty: PC<=SeqPC, count stays 0, RSUnderflow set.
- Sticky flags clear only on Reset.
- PCWrite=0 with any PCControl: no state change and no flag change.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: a CALL-while-full or RET-while-empty loads PC<=TRAP_VEC instead of the normal target. The sticky flag is still set and the stack behaviour is unchanged.
- Undefined: behaviour exactly as in Behaviour; the TRAP_VEC parameter is unused.

Decomposition:
- Package pc_seq_pkg: PCControl localparams (SEQ, BRANCH, JUMP, CALL, RET) and the PCCTRL_W=3 constant.
- Sub-module return_stack_p (params WIDTH, DEPTH):
  - Inputs: push, pop, wdata.
  - Outputs: top, full, empty, ovf_evt, unf_evt.
- pc_sequencer instantiates return_stack_p once and holds the PC register and flag logic.

Test Plan:
- Reset then 3 cycles SEQ with PCWrite=1 -> PC_out 0,2,4,6; RSEmpty=1; all flags 0.
- PC=0x0010, CALL Target=0x0100, then SEQ, then RET -> PC 0x0100, 0x0102, 0x0012; RSEmpty returns to 1.
- RS_DEPTH=8: 9 nested CALLs then 8 RETs -> RSOverflow=1 after the 9th call; the return sequence matches calls 9..2; the next RET sets RSUnderflow and PC<=SeqPC (PC_TRAP_EN undefined).
- PC=0xFFFE, SEQ -> PC_out=0x0000 with AddrWrap=1 for one cycle; PC=0x0020, BRANCH Offset=0xFFF0 -> PC 0x0010, AddrWrap=0.
- PCWrite=0 while PCControl=CALL for 4 cycles -> PC, stack count and flags unchanged; Reset asserted mid-call sequence -> next cycle PC=RESET_PC, stack empty, flags cleared.
- PC_TRAP_EN defined: RET when empty -> PC_out=0x0010 (TRAP_VEC), RSUnderflow=1.
